axi_read_slave_mem: RTL and testbench
=====================================

// Module: axi_read_slave_mem
// PURPOSE
//  AXI3-style read-channel slave (AR/R responder) backed by a word-addressed memory array.
//  Sits on one slave port of AXI_Interconnect (ARADDR_Sx/ARVALID_Sx/RREADY_Sx in; ARREADY/RVALID/RLAST/RRESP/RDATA out).
//  Serves FIXED/INCR/WRAP bursts of 1-16 beats, one outstanding transaction.
//  Includes a backdoor write port for preload.
// PARAMETERS
//  DATA_W     32    read data width; fixed at 32 (4 byte lanes)
//  ADDR_W     32    address width
//  DEPTH      256   memory depth in DATA_W words; power of 2
//  BASE_ADDR  0     byte address of mem[0]
// PORTS
//  G_clk     in   1       clock, all logic on rising edge
//  G_reset   in   1       synchronous reset, active-high
//  ARADDR    in   ADDR_W  read start byte address
//  ARLEN     in   4       beats-1
//  ARSIZE    in   3       bytes per beat = 1<<ARSIZE
//  ARBURST   in   2       00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//  ARVALID   in   1       address valid
//  ARREADY   out  1       address accepted
//  RVALID    out  1       read beat valid
//  RREADY    in   1       master accepts beat
//  RDATA     out  DATA_W  beat data (full word; master selects lanes)
//  RRESP     out  2       00 OKAY, 10 SLVERR
//  RLAST     out  1       final beat of burst
//  BD_WE     in   1       backdoor write enable
//  BD_IDX    in   log2(DEPTH)  backdoor word index
//  BD_WDATA  in   DATA_W  backdoor write data
// BEHAVIOUR
//  - Reset: ARREADY=0, RVALID=0, RLAST=0, RRESP=00, RDATA=0, FSM=IDLE. Memory is not cleared.
//    Reset mid-burst aborts the burst immediately with no further beats.
//  - ARREADY=1 from the first cycle after reset release.
//  - FSM states:
//    - IDLE: ARREADY=1. On ARVALID&&ARREADY, latch addr/len/size/burst, clear beat count, ARREADY<=0, go to DATA.
//    - DATA: RVALID rises the cycle after the AR handshake (1-cycle latency) with beat 0.
//      On RVALID&&RREADY, load the next beat the following cycle, so back-to-back beats are possible.
//      RVALID/RDATA/RRESP/RLAST stay stable while RREADY=0.
//      RLAST=1 exactly when beat count==ARLEN.
//      Last handshake -> RVALID<=0, ARREADY<=1, IDLE, giving 1 dead cycle between bursts.
//  - Address per beat, with sz=1<<size:
//    - FIXED: unchanged.
//    - INCR: next = (addr & ~(sz-1)) + sz. Crossing 4KB is not checked.
//    - WRAP: wb=(len+1)*sz; next = (addr & ~(wb-1)) | ((addr+sz) & (wb-1)).
//  - Word index = ((addr-BASE_ADDR)>>2) mod DEPTH.
//  - Error bursts still return ARLEN+1 beats with RDATA=0, RRESP=SLVERR on every beat:
//    - ARSIZE>2;
//    - ARBURST=11;
//    - WRAP with ARLEN not in {1,3,7,15};
//    - any beat failing the range check (see CONFIGURATION).
//  - Backdoor write and R beat load to the same word in the same cycle: the beat returns the OLD word; the write lands.
//  - ARVALID while in DATA is ignored (ARREADY=0); the master holds it per protocol.
// CONFIGURATION
//  AXI_RSLV_RANGE_CHECK_EN
//  - Defined: a beat address outside [BASE_ADDR, BASE_ADDR+DEPTH*4) returns RRESP=SLVERR, RDATA=0 for that beat only.
//  - Undefined: no range check; the index wraps modulo DEPTH and RRESP=OKAY unless another error rule applies.
// STRUCTURE
//  - Shared package/include axi_rd_defs:
//    - burst encodings (BURST_FIXED/INCR/WRAP);
//    - RESP_OKAY/RESP_SLVERR;
//    - FSM state encodings S_IDLE/S_DATA;
//    - AXI_LEN_W=4, AXI_SIZE_W=3.
//  - Sub-module axi_burst_addr_gen: combinational next-address from (addr, size, len, burst), plus a wrap-legality flag.
//    Reusable by the planned write-slave.
// TESTING
//  1. Preload mem[0..3]=A0..A3, BASE_ADDR=0; AR INCR addr=0 len=3 size=2, RREADY=1
//     -> 4 consecutive beats A0..A3, RLAST only on beat 4, RRESP=00.
//  2. AR WRAP addr=0x8 len=3 size=2 -> beats from words 2,3,0,1.
//     Repeat with len=2 -> 3 beats, all SLVERR, RDATA=0.
//  3. AR FIXED addr=0x4 len=2, RREADY toggled 1/0 -> mem[1] returned 3 times.
//     RDATA/RLAST held stable across every RREADY=0 cycle.
//  4. Range check, DEPTH=256, AR INCR addr=0x3F8 len=3 size=2:
//     - macro defined: beats 0-1 OKAY, beats 2-3 SLVERR;
//     - macro undefined: beats 2-3 return mem[0], mem[1] with OKAY.
//  5. Reset asserted after beat 1 of a len=7 burst:
//     - next cycle RVALID=0, ARREADY=0;
//     - one cycle after release ARREADY=1;
//     - a new AR is served from beat 0.
//  6. AR with ARSIZE=3 and with ARBURST=11 -> ARLEN+1 beats each, all SLVERR.
//     Back-to-back ARs show exactly 1 cycle of ARREADY=0 after RLAST before re-acceptance.

Source files
------------

// File: rtl/axi_rd_defs_pkg.sv
// Shared AXI read-side definitions: burst/response encodings, FSM states, field widths.
package axi_rd_defs_pkg;

    localparam int unsigned AXI_LEN_W  = 4;
    localparam int unsigned AXI_SIZE_W = 3;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DATA = 1'b1
    } state_e;

    // Burst control captured from the AR channel
    typedef struct packed {
        logic [AXI_LEN_W-1:0]  len;
        logic [AXI_SIZE_W-1:0] size;
        logic [1:0]            burst;
    } ar_ctrl_t;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats
    function automatic logic wrap_len_ok(input logic [AXI_LEN_W-1:0] len);
        return (len == AXI_LEN_W'(1)) || (len == AXI_LEN_W'(3)) ||
               (len == AXI_LEN_W'(7)) || (len == AXI_LEN_W'(15));
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: combinational next-beat address for FIXED/INCR/WRAP bursts,
// plus a flag telling whether the burst length is legal for WRAP.
module axi_burst_addr_gen
    import axi_rd_defs_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]     addr,
    input  logic [AXI_SIZE_W-1:0] size,
    input  logic [AXI_LEN_W-1:0]  len,
    input  logic [1:0]            burst,
    output logic [ADDR_W-1:0]     next_addr_c,
    output logic                  wrap_ok_c
);

    logic [ADDR_W-1:0] sz;
    logic [ADDR_W-1:0] wb;
    logic [ADDR_W-1:0] sz_mask;
    logic [ADDR_W-1:0] wb_mask;

    // Beat size, wrap boundary and the address arithmetic per burst type
    always_comb begin
        sz          = ADDR_W'(1) << size;
        wb          = (ADDR_W'(len) + ADDR_W'(1)) << size;
        sz_mask     = sz - ADDR_W'(1);
        wb_mask     = wb - ADDR_W'(1);
        next_addr_c = addr;
        case (burst)
            BURST_INCR: next_addr_c = (addr & ~sz_mask) + sz;
            BURST_WRAP: next_addr_c = (addr & ~wb_mask) | ((addr + sz) & wb_mask);
            default:    next_addr_c = addr;
        endcase
    end

    assign wrap_ok_c = wrap_len_ok(len);

endmodule

// File: rtl/axi_read_slave_mem.sv
// axi_read_slave_mem: AXI3 read-channel slave (AR/R) over a word-addressed memory,
// one outstanding burst, with a backdoor write port for preload.
// Optional: define AXI_RSLV_RANGE_CHECK_EN to return SLVERR for beats outside
// [BASE_ADDR, BASE_ADDR+DEPTH*4); otherwise the word index wraps modulo DEPTH.
module axi_read_slave_mem
    import axi_rd_defs_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DEPTH     = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                     G_clk,
    input  logic                     G_reset,
    input  logic [ADDR_W-1:0]        ARADDR,
    input  logic [AXI_LEN_W-1:0]     ARLEN,
    input  logic [AXI_SIZE_W-1:0]    ARSIZE,
    input  logic [1:0]               ARBURST,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    output logic                     RVALID,
    input  logic                     RREADY,
    output logic [DATA_W-1:0]        RDATA,
    output logic [1:0]               RRESP,
    output logic                     RLAST,
    input  logic                     BD_WE,
    input  logic [$clog2(DEPTH)-1:0] BD_IDX,
    input  logic [DATA_W-1:0]        BD_WDATA
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    state_e               state;
    logic [ADDR_W-1:0]    addr_q;
    ar_ctrl_t             ctrl_q;
    logic [AXI_LEN_W-1:0] beat_q;
    logic                 err_q;

    ar_ctrl_t             ar_ctrl;
    ar_ctrl_t             cur_ctrl;
    logic [ADDR_W-1:0]    next_addr;
    logic                 wrap_ok;
    logic                 cmd_err;
    logic                 burst_err;
    logic                 range_err;
    logic                 beat_err;
    logic [ADDR_W-1:0]    rd_addr;
    logic [IDX_W-1:0]     rd_idx;
    logic [DATA_W-1:0]    beat_data;
    logic [1:0]           beat_resp;

    // While idle the generator sees the incoming command (for WRAP legality);
    // during a burst it sees the captured one (for the next address)
    assign ar_ctrl  = '{len: ARLEN, size: ARSIZE, burst: ARBURST};
    assign cur_ctrl = (state == S_IDLE) ? ar_ctrl : ctrl_q;

    axi_burst_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .addr        (addr_q),
        .size        (cur_ctrl.size),
        .len         (cur_ctrl.len),
        .burst       (cur_ctrl.burst),
        .next_addr_c (next_addr),
        .wrap_ok_c   (wrap_ok)
    );

    // Whole-burst error conditions, evaluated on the command being accepted
    assign cmd_err = (cur_ctrl.size > AXI_SIZE_W'(2)) ||
                     (cur_ctrl.burst == BURST_RSVD) ||
                     ((cur_ctrl.burst == BURST_WRAP) && !wrap_ok);

    assign burst_err = (state == S_IDLE) ? cmd_err : err_q;

    // Beat 0 reads at ARADDR; later beats read at the next generated address
    assign rd_addr = (state == S_IDLE) ? ARADDR : next_addr;
    assign rd_idx  = IDX_W'((rd_addr - BASE_ADDR) >> 2);

`ifdef AXI_RSLV_RANGE_CHECK_EN
    localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH) << 2;

    logic [ADDR_W:0] rd_off;

    // A borrow below BASE_ADDR lands far above SPAN, so one compare covers both ends
    assign rd_off    = {1'b0, rd_addr} - {1'b0, BASE_ADDR};
    assign range_err = (rd_off >= SPAN);
`else
    assign range_err = 1'b0;
`endif

    assign beat_err  = burst_err || range_err;
    assign beat_data = beat_err ? '0 : mem[rd_idx];
    assign beat_resp = beat_err ? RESP_SLVERR : RESP_OKAY;

    // Backdoor preload; not reset, and a same-cycle beat load sees the old word
    always_ff @(posedge G_clk) begin
        if (BD_WE) begin
            mem[BD_IDX] <= BD_WDATA;
        end
    end

    // AR/R responder FSM with registered channel outputs
    always_ff @(posedge G_clk) begin
        if (G_reset) begin
            state   <= S_IDLE;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RLAST   <= 1'b0;
            RRESP   <= RESP_OKAY;
            RDATA   <= '0;
            addr_q  <= '0;
            ctrl_q  <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else if (state == S_IDLE) begin
            ARREADY <= 1'b1;
            if (ARVALID && ARREADY) begin
                ARREADY <= 1'b0;
                addr_q  <= ARADDR;
                ctrl_q  <= ar_ctrl;
                beat_q  <= '0;
                err_q   <= cmd_err;
                RVALID  <= 1'b1;
                RLAST   <= (ARLEN == '0);
                RDATA   <= beat_data;
                RRESP   <= beat_resp;
                state   <= S_DATA;
            end
        end else begin
            if (RVALID && RREADY) begin
                if (RLAST) begin
                    RVALID  <= 1'b0;
                    RLAST   <= 1'b0;
                    ARREADY <= 1'b1;
                    state   <= S_IDLE;
                end else begin
                    addr_q <= next_addr;
                    beat_q <= beat_q + AXI_LEN_W'(1);
                    RLAST  <= ((beat_q + AXI_LEN_W'(1)) == ctrl_q.len);
                    RDATA  <= beat_data;
                    RRESP  <= beat_resp;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_read_slave_mem.sv
// Bench for axi_read_slave_mem: table of bursts with hand-computed beats,
// plus hand sequences for reset mid-burst and backdoor/read collision.
module tb_axi_read_slave_mem;
    import axi_rd_defs_pkg::*;

    logic        G_clk;
    logic        G_reset;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        BD_WE;
    logic [7:0]  BD_IDX;
    logic [31:0] BD_WDATA;

    int total = 0;
    int bad   = 0;

    axi_read_slave_mem dut (
        .G_clk    (G_clk),
        .G_reset  (G_reset),
        .ARADDR   (ARADDR),
        .ARLEN    (ARLEN),
        .ARSIZE   (ARSIZE),
        .ARBURST  (ARBURST),
        .ARVALID  (ARVALID),
        .ARREADY  (ARREADY),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .RDATA    (RDATA),
        .RRESP    (RRESP),
        .RLAST    (RLAST),
        .BD_WE    (BD_WE),
        .BD_IDX   (BD_IDX),
        .BD_WDATA (BD_WDATA)
    );

    initial G_clk = 1'b0;
    always #5 G_clk = ~G_clk;

    typedef struct {
        logic [31:0]      addr;
        logic [3:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        bit               toggle;
        logic [3:0][31:0] data;
        logic [3:0][1:0]  resp;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    function automatic logic [31:0] dword(input int w);
        return 32'hA500_0000 | 32'(w);
    endfunction

    // Expected beats given as word indices; a negative index means an SLVERR beat
    function automatic vec_t mk(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                                input logic [1:0] b, input bit t,
                                input int w0, input int w1, input int w2, input int w3);
        vec_t v;
        int   w[4];
        w = '{w0, w1, w2, w3};
        v.addr   = a;
        v.len    = l;
        v.size   = s;
        v.burst  = b;
        v.toggle = t;
        for (int k = 0; k < 4; k++) begin
            v.data[k] = (w[k] < 0) ? 32'h0 : dword(w[k]);
            v.resp[k] = (w[k] < 0) ? RESP_SLVERR : RESP_OKAY;
        end
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Present an AR, wait (bounded) for acceptance, expect beat 0 right after
    task automatic do_ar(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                         input logic [1:0] b);
        int n;
        n = 0;
        ARADDR  = a;
        ARLEN   = l;
        ARSIZE  = s;
        ARBURST = b;
        ARVALID = 1'b1;
        while (ARREADY !== 1'b1 && n < 20) begin
            @(posedge G_clk); #1;
            n++;
        end
        chk("arready_wait", 32'(ARREADY), 32'd1);
        @(posedge G_clk); #1;
        ARVALID = 1'b0;
        chk("rvalid_rise", 32'(RVALID), 32'd1);
    endtask

    initial begin
        G_reset  = 1'b1;
        ARADDR   = '0;
        ARLEN    = '0;
        ARSIZE   = '0;
        ARBURST  = '0;
        ARVALID  = 1'b0;
        RREADY   = 1'b0;
        BD_WE    = 1'b0;
        BD_IDX   = '0;
        BD_WDATA = '0;

        vecs[0]  = mk(32'h0,   4'd3, 3'd2, BURST_INCR,  1'b0, 0, 1, 2, 3);
        vecs[1]  = mk(32'h8,   4'd3, 3'd2, BURST_WRAP,  1'b0, 2, 3, 0, 1);
        vecs[2]  = mk(32'h8,   4'd2, 3'd2, BURST_WRAP,  1'b0, -1, -1, -1, 0);
        vecs[3]  = mk(32'h4,   4'd2, 3'd2, BURST_FIXED, 1'b1, 1, 1, 1, 0);
`ifdef AXI_RSLV_RANGE_CHECK_EN
        vecs[4]  = mk(32'h3F8, 4'd3, 3'd2, BURST_INCR,  1'b0, 254, 255, -1, -1);
`else
        vecs[4]  = mk(32'h3F8, 4'd3, 3'd2, BURST_INCR,  1'b0, 254, 255, 0, 1);
`endif
        vecs[5]  = mk(32'h0,   4'd1, 3'd3, BURST_INCR,  1'b0, -1, -1, 0, 0);
        vecs[6]  = mk(32'h0,   4'd2, 3'd2, BURST_RSVD,  1'b0, -1, -1, -1, 0);
        vecs[7]  = mk(32'h2,   4'd3, 3'd1, BURST_INCR,  1'b0, 0, 1, 1, 2);
        vecs[8]  = mk(32'h5,   4'd1, 3'd2, BURST_INCR,  1'b1, 1, 2, 0, 0);
        vecs[9]  = mk(32'h20,  4'd0, 3'd2, BURST_INCR,  1'b0, 8, 0, 0, 0);
        vecs[10] = mk(32'h4,   4'd1, 3'd2, BURST_WRAP,  1'b0, 1, 0, 0, 0);

        // Preload the whole memory while reset is held; memory is not reset
        @(posedge G_clk); #1;
        for (int i = 0; i < 256; i++) begin
            BD_WE    = 1'b1;
            BD_IDX   = 8'(i);
            BD_WDATA = dword(i);
            @(posedge G_clk); #1;
        end
        BD_WE = 1'b0;

        chk("rst_arready", 32'(ARREADY), 32'd0);
        chk("rst_rvalid",  32'(RVALID),  32'd0);
        chk("rst_rlast",   32'(RLAST),   32'd0);
        chk("rst_rresp",   32'(RRESP),   32'd0);
        chk("rst_rdata",   RDATA,        32'd0);

        G_reset = 1'b0;
        @(posedge G_clk); #1;
        chk("rel_arready", 32'(ARREADY), 32'd1);

        // Table-driven bursts, issued back to back
        for (int i = 0; i < NV; i++) begin
            do_ar(vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst);
            for (int k = 0; k <= int'(vecs[i].len); k++) begin
                chk($sformatf("v%0d_b%0d_valid", i, k), 32'(RVALID), 32'd1);
                chk($sformatf("v%0d_b%0d_data", i, k), RDATA, vecs[i].data[k]);
                chk($sformatf("v%0d_b%0d_resp", i, k), 32'(RRESP), 32'(vecs[i].resp[k]));
                chk($sformatf("v%0d_b%0d_last", i, k), 32'(RLAST),
                    (k == int'(vecs[i].len)) ? 32'd1 : 32'd0);
                if (vecs[i].toggle) begin
                    RREADY = 1'b0;
                    @(posedge G_clk); #1;
                    chk($sformatf("v%0d_b%0d_hold_valid", i, k), 32'(RVALID), 32'd1);
                    chk($sformatf("v%0d_b%0d_hold_data", i, k), RDATA, vecs[i].data[k]);
                    chk($sformatf("v%0d_b%0d_hold_last", i, k), 32'(RLAST),
                        (k == int'(vecs[i].len)) ? 32'd1 : 32'd0);
                end
                RREADY = 1'b1;
                @(posedge G_clk); #1;
            end
            RREADY = 1'b0;
            chk($sformatf("v%0d_dead_rvalid", i), 32'(RVALID), 32'd0);
            chk($sformatf("v%0d_dead_arready", i), 32'(ARREADY), 32'd1);
        end

        // Reset after beat 1 of an 8-beat burst aborts it
        do_ar(32'h0, 4'd7, 3'd2, BURST_INCR);
        RREADY = 1'b1;
        @(posedge G_clk); #1;
        chk("rstmid_beat1", RDATA, dword(1));
        @(posedge G_clk); #1;
        G_reset = 1'b1;
        RREADY  = 1'b0;
        @(posedge G_clk); #1;
        chk("rstmid_rvalid",  32'(RVALID),  32'd0);
        chk("rstmid_arready", 32'(ARREADY), 32'd0);
        G_reset = 1'b0;
        @(posedge G_clk); #1;
        chk("rstmid_rel_arready", 32'(ARREADY), 32'd1);
        do_ar(32'h10, 4'd1, 3'd2, BURST_INCR);
        chk("rstmid_new_b0", RDATA, dword(4));
        chk("rstmid_new_b0_last", 32'(RLAST), 32'd0);
        RREADY = 1'b1;
        @(posedge G_clk); #1;
        chk("rstmid_new_b1", RDATA, dword(5));
        chk("rstmid_new_b1_last", 32'(RLAST), 32'd1);
        @(posedge G_clk); #1;
        RREADY = 1'b0;
        chk("rstmid_new_done", 32'(RVALID), 32'd0);

        // Backdoor write to the word loaded by beat 0 in the same cycle
        ARADDR   = 32'h10;
        ARLEN    = 4'd1;
        ARSIZE   = 3'd2;
        ARBURST  = BURST_FIXED;
        ARVALID  = 1'b1;
        BD_WE    = 1'b1;
        BD_IDX   = 8'd4;
        BD_WDATA = 32'hDEAD_BEEF;
        chk("coll_arready", 32'(ARREADY), 32'd1);
        @(posedge G_clk); #1;
        ARVALID = 1'b0;
        BD_WE   = 1'b0;
        chk("coll_old_word", RDATA, dword(4));
        RREADY = 1'b1;
        @(posedge G_clk); #1;
        chk("coll_new_word", RDATA, 32'hDEAD_BEEF);
        chk("coll_last", 32'(RLAST), 32'd1);
        @(posedge G_clk); #1;
        RREADY = 1'b0;
        chk("coll_done", 32'(RVALID), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
